// File: rtl/exc_pkg.sv
// Shared definitions for the exception sequencer, the main control unit and the address mux.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SAVE  = 2'b01,
        ST_FETCH = 2'b10,
        ST_LOAD  = 2'b11
    } state_e;

    typedef enum logic [1:0] {
        CAUSE_NONE   = 2'b00,
        CAUSE_OPCODE = 2'b01,
        CAUSE_OVF    = 2'b10,
        CAUSE_DIV0   = 2'b11
    } cause_e;

    localparam logic [2:0] SEL_PC   = 3'b000;
    localparam logic [2:0] SEL_V253 = 3'b100;
    localparam logic [2:0] SEL_V254 = 3'b101;
    localparam logic [2:0] SEL_V255 = 3'b110;

    // Maps a cause to the address-mux code of its handler vector byte.
    function automatic logic [2:0] vec_sel(input cause_e c);
        logic [2:0] s;
        case (c)
            CAUSE_OPCODE: s = SEL_V253;
            CAUSE_OVF:    s = SEL_V254;
            CAUSE_DIV0:   s = SEL_V255;
            default:      s = SEL_PC;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/exc_sequencer_prio.sv
// Fixed-priority encoder from the three exception events to a cause code (opcode > overflow > div0).
module exc_prio
    import exc_pkg::*;
(
    input  logic   i_opcode,
    input  logic   i_overflow,
    input  logic   i_div0,
    output cause_e o_cause
);

    // Highest-priority active event wins; the rest are dropped.
    always_comb begin
        o_cause = CAUSE_NONE;
        if (i_opcode) begin
            o_cause = CAUSE_OPCODE;
        end else if (i_overflow) begin
            o_cause = CAUSE_OVF;
        end else if (i_div0) begin
            o_cause = CAUSE_DIV0;
        end else begin
            o_cause = CAUSE_NONE;
        end
    end

endmodule

// File: rtl/exc_sequencer.sv
// Multicycle exception sequencer: saves EPC, fetches the handler byte from the vector
// area and loads PC, stalling the main control unit meanwhile.
module exc_sequencer
    import exc_pkg::*;
#(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] pc_current,
    input  logic [7:0]  mem_rdata,
    output logic [2:0]  mem_addr_sel,
    output logic        mem_read,
    output logic        epc_wr,
    output logic [31:0] epc_value,
    output logic        pc_wr,
    output logic [31:0] pc_value,
    output logic [1:0]  cause,
    output logic        busy,
    output logic        done
);

    localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT) : 1;
    localparam logic [CW-1:0] WAIT_LOAD = CW'(MEM_WAIT - 1);

    state_e         r_state;
    state_e         w_state_nxt;
    cause_e         r_cause;
    cause_e         w_cause;
    logic [31:0]    r_epc;
    logic [CW-1:0]  r_cnt;

    exc_prio u_prio (
        .i_opcode   (exc_opcode),
        .i_overflow (exc_overflow),
        .i_div0     (exc_div0),
        .o_cause    (w_cause)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; events are only looked at while idle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cause != CAUSE_NONE) begin
                    w_state_nxt = ST_SAVE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SAVE:  w_state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (r_cnt == {CW{1'b0}}) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_LOAD:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Cause, saved PC and memory wait counter; cause persists until the next exception.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cause <= CAUSE_NONE;
            r_epc   <= 32'h0000_0000;
            r_cnt   <= {CW{1'b0}};
        end else begin
            if (r_state == ST_IDLE && w_cause != CAUSE_NONE) begin
                r_cause <= w_cause;
                r_epc   <= pc_current - 32'd4;
            end
            if (r_state == ST_SAVE) begin
                r_cnt <= WAIT_LOAD;
            end else if (r_state == ST_FETCH && r_cnt != {CW{1'b0}}) begin
                r_cnt <= r_cnt - CW'(1);
            end
        end
    end

    // Outputs decoded purely from registered state, so events never reach them combinationally.
    always_comb begin
        mem_addr_sel = SEL_PC;
        mem_read     = 1'b0;
        epc_wr       = 1'b0;
        epc_value    = 32'h0000_0000;
        pc_wr        = 1'b0;
        pc_value     = 32'h0000_0000;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_SAVE: begin
                mem_addr_sel = vec_sel(r_cause);
                mem_read     = 1'b1;
                epc_wr       = 1'b1;
                epc_value    = r_epc;
                busy         = 1'b1;
            end
            ST_FETCH: begin
                mem_addr_sel = vec_sel(r_cause);
                mem_read     = 1'b1;
                busy         = 1'b1;
            end
            ST_LOAD: begin
                mem_addr_sel = vec_sel(r_cause);
                mem_read     = 1'b1;
                pc_wr        = 1'b1;
                pc_value     = {24'h00_0000, mem_rdata};
                busy         = 1'b1;
                done         = 1'b1;
            end
            default: begin
                mem_addr_sel = SEL_PC;
            end
        endcase
    end

    assign cause = r_cause;

endmodule

// File: tb/tb_exc_sequencer.sv
// Randomized bench for exc_sequencer: two instances (MEM_WAIT 2 and 1) checked every cycle
// against a timeline model of the exception sequence, plus directed literal checks.
module tb_exc_sequencer;

    localparam int MWV [2] = '{2, 1};

    logic        clk          = 1'b0;
    logic        reset        = 1'b1;
    logic        exc_opcode   = 1'b0;
    logic        exc_overflow = 1'b0;
    logic        exc_div0     = 1'b0;
    logic [31:0] pc_current   = 32'h0;

    logic [7:0]  mem_rdata [2];
    logic [2:0]  sel       [2];
    logic        mem_read  [2];
    logic        epc_wr    [2];
    logic [31:0] epc_value [2];
    logic        pc_wr     [2];
    logic [31:0] pc_value  [2];
    logic [1:0]  cause     [2];
    logic        busy      [2];
    logic        done      [2];

    logic [7:0]  vmem [3] = '{8'h11, 8'h22, 8'h33};

    logic        m_active [2] = '{1'b0, 1'b0};
    int          m_k      [2] = '{0, 0};
    logic [1:0]  m_cause  [2] = '{2'd0, 2'd0};
    logic [31:0] m_epc    [2] = '{32'h0, 32'h0};

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    exc_sequencer #(.MEM_WAIT(2)) u_dut0 (
        .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
        .exc_div0(exc_div0), .pc_current(pc_current), .mem_rdata(mem_rdata[0]),
        .mem_addr_sel(sel[0]), .mem_read(mem_read[0]), .epc_wr(epc_wr[0]),
        .epc_value(epc_value[0]), .pc_wr(pc_wr[0]), .pc_value(pc_value[0]),
        .cause(cause[0]), .busy(busy[0]), .done(done[0])
    );

    exc_sequencer #(.MEM_WAIT(1)) u_dut1 (
        .clk(clk), .reset(reset), .exc_opcode(exc_opcode), .exc_overflow(exc_overflow),
        .exc_div0(exc_div0), .pc_current(pc_current), .mem_rdata(mem_rdata[1]),
        .mem_addr_sel(sel[1]), .mem_read(mem_read[1]), .epc_wr(epc_wr[1]),
        .epc_value(epc_value[1]), .pc_wr(pc_wr[1]), .pc_value(pc_value[1]),
        .cause(cause[1]), .busy(busy[1]), .done(done[1])
    );

    // Memory: vector bytes at 253..255, anything else reads a filler byte.
    assign mem_rdata[0] = (sel[0] == 3'b100) ? vmem[0] : (sel[0] == 3'b101) ? vmem[1] :
                          (sel[0] == 3'b110) ? vmem[2] : 8'hA5;
    assign mem_rdata[1] = (sel[1] == 3'b100) ? vmem[0] : (sel[1] == 3'b101) ? vmem[1] :
                          (sel[1] == 3'b110) ? vmem[2] : 8'hA5;

    // Timeline model: k counts cycles since the event was taken (1 = save, MW+2 = load).
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_active[d] <= 1'b0;
                m_k[d]      <= 0;
                m_cause[d]  <= 2'd0;
                m_epc[d]    <= 32'h0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!m_active[d]) begin
                    if (exc_opcode || exc_overflow || exc_div0) begin
                        m_active[d] <= 1'b1;
                        m_k[d]      <= 1;
                        m_cause[d]  <= exc_opcode ? 2'd1 : (exc_overflow ? 2'd2 : 2'd3);
                        m_epc[d]    <= pc_current - 32'd4;
                    end
                end else if (m_k[d] == MWV[d] + 2) begin
                    m_active[d] <= 1'b0;
                    m_k[d]      <= 0;
                end else begin
                    m_k[d] <= m_k[d] + 1;
                end
            end
        end
    end

    task automatic compare();
        for (int d = 0; d < 2; d++) begin
            logic [2:0]  e_sel;
            logic        e_ewr, e_pwr;
            logic [31:0] e_epc, e_pcv;
            int          idx;
            e_ewr = m_active[d] && (m_k[d] == 1);
            e_pwr = m_active[d] && (m_k[d] == MWV[d] + 2);
            idx   = int'(m_cause[d]) - 1;
            if (idx < 0) idx = 0;
            e_sel = m_active[d] ? 3'(32'd3 + 32'(m_cause[d])) : 3'b000;
            e_epc = e_ewr ? m_epc[d] : 32'h0;
            e_pcv = e_pwr ? {24'h0, vmem[idx]} : 32'h0;
            n_vec++;
            if ({sel[d], mem_read[d], epc_wr[d], epc_value[d], pc_wr[d], pc_value[d], cause[d], busy[d], done[d]}
                !== {e_sel, m_active[d], e_ewr, e_epc, e_pwr, e_pcv, m_cause[d], m_active[d], e_pwr}) begin
                n_bad++;
                $display("FAIL cycle_dut%0d t=%0t: got sel=%b rd=%b ewr=%b epc=%h pwr=%b pcv=%h cause=%b busy=%b done=%b, required sel=%b rd=%b ewr=%b epc=%h pwr=%b pcv=%h cause=%b busy=%b done=%b",
                         d, $time, sel[d], mem_read[d], epc_wr[d], epc_value[d], pc_wr[d], pc_value[d], cause[d], busy[d], done[d],
                         e_sel, m_active[d], e_ewr, e_epc, e_pwr, e_pcv, m_cause[d], m_active[d], e_pwr);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    initial begin
        int n_a, n_b, n_c;
        logic [31:0] pcv;
        #1 reset = 1'b0;
        exc_div0   = 1'b1;
        pc_current = 32'h0000_0100;
        repeat (3) tick();
        chk("rst_sel", 32'(sel[0]), 32'h0);
        chk("rst_busy", 32'(busy[0]), 32'h0);
        chk("rst_cause", 32'(cause[0]), 32'h0);
        reset = 1'b1;
        tick();
        chk("div0_start_busy", 32'(busy[0]), 32'h1);
        chk("div0_start_cause", 32'(cause[0]), 32'h3);
        chk("div0_start_epc", epc_value[0], 32'h0000_00FC);
        exc_div0 = 1'b0;
        repeat (5) tick();

        // Overflow with handler byte 0x7C at address 254.
        vmem[1] = 8'h7C;
        pc_current = 32'h0000_0048;
        exc_overflow = 1'b1;
        tick();
        exc_overflow = 1'b0;
        chk("ovf_epc_wr", 32'(epc_wr[0]), 32'h1);
        chk("ovf_epc_value", epc_value[0], 32'h0000_0044);
        n_a = 0; n_b = 0; n_c = 0; pcv = 32'h0;
        for (int c = 0; c < 6; c++) begin
            if (sel[0] == 3'b101) n_a++;
            if (pc_wr[0]) begin n_b++; pcv = pc_value[0]; end
            if (done[0]) n_c++;
            tick();
        end
        chk("ovf_sel_cycles", 32'(n_a), 32'd4);
        chk("ovf_pc_wr_count", 32'(n_b), 32'd1);
        chk("ovf_pc_value", pcv, 32'h0000_007C);
        chk("ovf_done_count", 32'(n_c), 32'd1);
        chk("ovf_cause", 32'(cause[0]), 32'h2);

        // Simultaneous opcode and div0: opcode wins, no follow-up sequence.
        exc_opcode = 1'b1;
        exc_div0   = 1'b1;
        tick();
        exc_opcode = 1'b0;
        exc_div0   = 1'b0;
        chk("sim_sel", 32'(sel[0]), 32'h4);
        chk("sim_cause", 32'(cause[0]), 32'h1);
        n_a = 0;
        for (int c = 0; c < 8; c++) begin
            if (busy[0]) n_a++;
            tick();
        end
        chk("sim_busy_cycles", 32'(n_a), 32'd4);

        // Overflow during FETCH of a div0 sequence is ignored.
        exc_div0 = 1'b1;
        tick();
        exc_div0 = 1'b0;
        tick();
        exc_overflow = 1'b1;
        tick();
        exc_overflow = 1'b0;
        n_a = 0;
        for (int c = 0; c < 6; c++) begin
            if (pc_wr[0]) n_a++;
            tick();
        end
        chk("ign_pc_wr_count", 32'(n_a), 32'd1);
        chk("ign_cause", 32'(cause[0]), 32'h3);

        // Reset asserted during FETCH aborts immediately.
        exc_div0 = 1'b1;
        tick();
        exc_div0 = 1'b0;
        tick();
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_busy", 32'(busy[0]), 32'h0);
        chk("abort_read", 32'(mem_read[0]), 32'h0);
        chk("abort_sel", 32'(sel[0]), 32'h0);
        @(negedge clk);
        compare();
        repeat (2) tick();
        reset = 1'b1;
        n_a = 0;
        for (int c = 0; c < 6; c++) begin
            if (pc_wr[0]) n_a++;
            tick();
        end
        chk("abort_no_pc_wr", 32'(n_a), 32'd0);

        // pc_current = 0 wraps; MEM_WAIT = 1 instance loads after a single FETCH cycle.
        pc_current = 32'h0;
        exc_overflow = 1'b1;
        tick();
        exc_overflow = 1'b0;
        chk("wrap_epc_wr", 32'(epc_wr[1]), 32'h1);
        chk("wrap_epc_value", epc_value[1], 32'hFFFF_FFFC);
        tick();
        chk("mw1_fetch_no_pc_wr", 32'(pc_wr[1]), 32'h0);
        chk("mw1_fetch_busy", 32'(busy[1]), 32'h1);
        tick();
        chk("mw1_load_pc_wr", 32'(pc_wr[1]), 32'h1);
        repeat (3) tick();

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 500; i++) begin
            if (!m_active[0] && !m_active[1] && $urandom_range(0, 3) == 0) begin
                vmem[0] = 8'($urandom());
                vmem[1] = 8'($urandom());
                vmem[2] = 8'($urandom());
            end
            pc_current   = $urandom();
            exc_opcode   = ($urandom_range(0, 99) < 6);
            exc_overflow = ($urandom_range(0, 99) < 8);
            exc_div0     = ($urandom_range(0, 99) < 8);
            if ($urandom_range(0, 99) < 2) begin
                @(posedge clk);
                #2 reset = 1'b0;
                @(negedge clk);
                compare();
                reset = 1'b1;
            end else begin
                tick();
            end
        end
        exc_opcode   = 1'b0;
        exc_overflow = 1'b0;
        exc_div0     = 1'b0;
        repeat (6) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
